// File: rtl/synth_pkg.sv
// Shared voice-synth types and constants: envelope FSM states, level ceiling,
// and the velocity width used when ADSR_VELOCITY_EN is defined.
package synth_pkg;

    localparam int          VEL_W     = 7;
    localparam logic [15:0] LEVEL_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

    // A zero rate would stall a phase forever, so it is promoted to one.
    function automatic logic [15:0] rate_min1(input logic [15:0] rate);
        return (rate == 16'd0) ? 16'd1 : rate;
    endfunction

endpackage

// File: rtl/sat_step.sv
// Saturating 16-bit add (ceiling LEVEL_MAX) or subtract (floor = limit).
// The hit flag reports that the clamp engaged, which ends the current phase.
module sat_step
    import synth_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] limit,
    input  logic        sub,
    output logic [15:0] y,
    output logic        hit
);

    logic [16:0] sum_s;
    logic [16:0] diff_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Clamp the 17-bit result; diff_s[16] set means the subtraction borrowed.
    always_comb begin
        y   = a;
        hit = 1'b0;
        if (sub) begin
            if (diff_s[16] || (diff_s[15:0] <= limit)) begin
                y   = limit;
                hit = 1'b1;
            end else begin
                y   = diff_s[15:0];
                hit = 1'b0;
            end
        end else begin
            if (sum_s >= {1'b0, LEVEL_MAX}) begin
                y   = LEVEL_MAX;
                hit = 1'b1;
            end else begin
                y   = sum_s[15:0];
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator with a one-cycle amplitude load strobe.
// Optional ADSR_VELOCITY_EN scales the output by a latched key velocity.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int LEVEL_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Tick,
    input  logic               Gate,
    input  logic [LEVEL_W-1:0] AttackInc,
    input  logic [LEVEL_W-1:0] DecayDec,
    input  logic [LEVEL_W-1:0] SustainLvl,
    input  logic [LEVEL_W-1:0] ReleaseDec,
`ifdef ADSR_VELOCITY_EN
    input  logic [VEL_W-1:0]   Velocity,
`endif
    output logic [LEVEL_W-1:0] A_out,
    output logic               loadA,
    output logic               Active
);

    adsr_state_t        state_r, state_next_s;
    logic [LEVEL_W-1:0] level_r, level_next_s;
    logic               gate_q_r, load_r, active_r;
    logic               rise_s, fall_s;
    logic [LEVEL_W-1:0] atk_s, dec_s, rel_s;
    logic [LEVEL_W-1:0] step_b_s, step_limit_s, step_y_s;
    logic               step_sub_s, step_hit_s;

    assign rise_s = Gate & ~gate_q_r;
    assign fall_s = ~Gate & gate_q_r;
    assign atk_s  = rate_min1(AttackInc);
    assign dec_s  = rate_min1(DecayDec);
    assign rel_s  = rate_min1(ReleaseDec);

    sat_step u_step (
        .a     (level_r),
        .b     (step_b_s),
        .limit (step_limit_s),
        .sub   (step_sub_s),
        .y     (step_y_s),
        .hit   (step_hit_s)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decision; a gate edge outranks the phase's own limit exit.
    always_comb begin
        state_next_s = state_r;
        if (Tick) begin
            case (state_r)
                ST_IDLE:    state_next_s = rise_s ? ST_ATTACK : ST_IDLE;
                ST_ATTACK:  state_next_s = fall_s ? ST_RELEASE : (step_hit_s ? ST_DECAY : ST_ATTACK);
                ST_DECAY:   state_next_s = fall_s ? ST_RELEASE : (step_hit_s ? ST_SUSTAIN : ST_DECAY);
                ST_SUSTAIN: state_next_s = fall_s ? ST_RELEASE : ST_SUSTAIN;
                ST_RELEASE: state_next_s = rise_s ? ST_ATTACK : (step_hit_s ? ST_IDLE : ST_RELEASE);
                default:    state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Step operand selection and next level for the current state.
    always_comb begin
        step_b_s     = atk_s;
        step_sub_s   = 1'b0;
        step_limit_s = {LEVEL_W{1'b0}};
        level_next_s = level_r;
        case (state_r)
            ST_ATTACK, ST_DECAY, ST_SUSTAIN: begin
                if (fall_s) begin
                    step_b_s   = rel_s;
                    step_sub_s = 1'b1;
                end else if (state_r == ST_DECAY) begin
                    step_b_s     = dec_s;
                    step_sub_s   = 1'b1;
                    step_limit_s = SustainLvl;
                end else begin
                    step_b_s = atk_s;
                end
            end
            ST_RELEASE: begin
                if (rise_s) begin
                    step_b_s = atk_s;
                end else begin
                    step_b_s   = rel_s;
                    step_sub_s = 1'b1;
                end
            end
            default: step_b_s = atk_s;
        endcase
        if (Tick) begin
            case (state_r)
                ST_IDLE:    level_next_s = {LEVEL_W{1'b0}};
                ST_SUSTAIN: level_next_s = fall_s ? step_y_s : SustainLvl;
                ST_ATTACK, ST_DECAY, ST_RELEASE: level_next_s = step_y_s;
                default:    level_next_s = {LEVEL_W{1'b0}};
            endcase
        end else begin
            level_next_s = level_r;
        end
    end

    // Level, gate history and registered strobes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            level_r  <= {LEVEL_W{1'b0}};
            gate_q_r <= 1'b0;
            load_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            level_r  <= level_next_s;
            gate_q_r <= Tick ? Gate : gate_q_r;
            load_r   <= Tick;
            active_r <= (state_next_s != ST_IDLE);
        end
    end

    assign Active = active_r;

`ifdef ADSR_VELOCITY_EN
    logic [VEL_W-1:0]         vel_r;
    logic [LEVEL_W+VEL_W:0]   prod_s;
    logic [LEVEL_W-1:0]       a_out_r;
    logic                     load2_r;

    assign prod_s = level_r * {vel_r, 1'b1};

    // Velocity latch and scaling pipeline stage, strobe delayed to match.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vel_r   <= {VEL_W{1'b0}};
            a_out_r <= {LEVEL_W{1'b0}};
            load2_r <= 1'b0;
        end else begin
            vel_r   <= (Tick && rise_s) ? Velocity : vel_r;
            a_out_r <= prod_s[LEVEL_W+VEL_W:VEL_W+1];
            load2_r <= load_r;
        end
    end

    assign A_out = a_out_r;
    assign loadA = load2_r;
`else
    assign A_out = level_r;
    assign loadA = load_r;
`endif

endmodule

// File: tb/tb_adsr_envelope.sv
// Table-driven bench for adsr_envelope (default build, 1-cycle output latency).
module tb_adsr_envelope;
    import synth_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Tick = 1'b0;
    logic        Gate = 1'b0;
    logic [15:0] AttackInc = 16'd0;
    logic [15:0] DecayDec = 16'd0;
    logic [15:0] SustainLvl = 16'd0;
    logic [15:0] ReleaseDec = 16'd0;
    logic [6:0]  Velocity = 7'd64;
    logic [15:0] A_out;
    logic        loadA;
    logic        Active;

    int n_tests = 0;
    int n_fail  = 0;

    adsr_envelope #(.LEVEL_W(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Tick       (Tick),
        .Gate       (Gate),
        .AttackInc  (AttackInc),
        .DecayDec   (DecayDec),
        .SustainLvl (SustainLvl),
        .ReleaseDec (ReleaseDec),
`ifdef ADSR_VELOCITY_EN
        .Velocity   (Velocity),
`endif
        .A_out      (A_out),
        .loadA      (loadA),
        .Active     (Active)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        gate;
        logic [15:0] ai;
        logic [15:0] dd;
        logic [15:0] sl;
        logic [15:0] rd;
        logic [15:0] lvl;
        logic        act;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'h0000, 1'b1};
        vecs[4]  = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'h4000, 1'b1};
        vecs[5]  = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'h8000, 1'b1};
        vecs[6]  = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'hC000, 1'b1};
        vecs[7]  = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'hFFFF, 1'b1};
        vecs[8]  = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'hEFFF, 1'b1};
        vecs[9]  = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'hDFFF, 1'b1};
        vecs[10] = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'hCFFF, 1'b1};
        vecs[11] = '{1'b1, 16'h4000, 16'h1000, 16'hC800, 16'h3000, 16'hC800, 1'b1};
        vecs[12] = '{1'b1, 16'h4000, 16'h1000, 16'hA000, 16'h3000, 16'hA000, 1'b1};
        vecs[13] = '{1'b0, 16'h4000, 16'h1000, 16'hA000, 16'h3000, 16'h7000, 1'b1};
        vecs[14] = '{1'b0, 16'h4000, 16'h1000, 16'hA000, 16'h3000, 16'h4000, 1'b1};
        vecs[15] = '{1'b0, 16'h4000, 16'h1000, 16'hA000, 16'h3000, 16'h1000, 1'b1};
        vecs[16] = '{1'b0, 16'h4000, 16'h1000, 16'hA000, 16'h3000, 16'h0000, 1'b0};
        vecs[17] = '{1'b1, 16'h4000, 16'h1000, 16'hA000, 16'h3000, 16'h0000, 1'b1};
        vecs[18] = '{1'b1, 16'h4000, 16'h1000, 16'hA000, 16'h3000, 16'h4000, 1'b1};
        vecs[19] = '{1'b1, 16'h4000, 16'h1000, 16'hA000, 16'h3000, 16'h8000, 1'b1};
        vecs[20] = '{1'b0, 16'h4000, 16'h1000, 16'hA000, 16'h4000, 16'h4000, 1'b1};
        vecs[21] = '{1'b1, 16'h4000, 16'h1000, 16'hA000, 16'h4000, 16'h8000, 1'b1};
        vecs[22] = '{1'b1, 16'h0000, 16'h1000, 16'hA000, 16'h4000, 16'h8001, 1'b1};
        vecs[23] = '{1'b1, 16'h8000, 16'h1000, 16'hA000, 16'h4000, 16'hFFFF, 1'b1};
        vecs[24] = '{1'b1, 16'h8000, 16'h1000, 16'hFFFF, 16'h4000, 16'hFFFF, 1'b1};
        vecs[25] = '{1'b1, 16'h8000, 16'h1000, 16'h1234, 16'h4000, 16'h1234, 1'b1};

        step_edge();
        step_edge();
        chk("reset_a_out", {16'd0, A_out}, 32'd0);
        chk("reset_loada", {31'd0, loadA}, 32'd0);
        chk("reset_active", {31'd0, Active}, 32'd0);
        Reset = 1'b0;
        step_edge();

        for (int i = 0; i < 26; i++) begin
            Gate       = vecs[i].gate;
            AttackInc  = vecs[i].ai;
            DecayDec   = vecs[i].dd;
            SustainLvl = vecs[i].sl;
            ReleaseDec = vecs[i].rd;
            Tick       = 1'b1;
            step_edge();
            Tick = 1'b0;
            chk($sformatf("v%0d_level", i), {16'd0, A_out}, {16'd0, vecs[i].lvl});
            chk($sformatf("v%0d_loada", i), {31'd0, loadA}, 32'd1);
            chk($sformatf("v%0d_active", i), {31'd0, Active}, {31'd0, vecs[i].act});
            step_edge();
            chk($sformatf("v%0d_loada_off", i), {31'd0, loadA}, 32'd0);
            chk($sformatf("v%0d_hold", i), {16'd0, A_out}, {16'd0, vecs[i].lvl});
        end

        // Reset from SUSTAIN without a tick.
        Reset = 1'b1;
        step_edge();
        Reset = 1'b0;
        chk("rst_sus_level", {16'd0, A_out}, 32'd0);
        chk("rst_sus_active", {31'd0, Active}, 32'd0);

        // Gate pulse entirely between ticks must not start an envelope.
        Gate = 1'b1;
        step_edge();
        step_edge();
        Gate = 1'b0;
        step_edge();
        Tick = 1'b1;
        step_edge();
        Tick = 1'b0;
        chk("glitch_level", {16'd0, A_out}, 32'd0);
        chk("glitch_loada", {31'd0, loadA}, 32'd1);
        chk("glitch_active", {31'd0, Active}, 32'd0);

        // Back-to-back ticks, each advances one step.
        Gate      = 1'b1;
        AttackInc = 16'h4000;
        Tick      = 1'b1;
        step_edge();
        chk("b2b0_level", {16'd0, A_out}, 32'h0000);
        chk("b2b0_active", {31'd0, Active}, 32'd1);
        step_edge();
        chk("b2b1_level", {16'd0, A_out}, 32'h4000);
        chk("b2b1_loada", {31'd0, loadA}, 32'd1);
        step_edge();
        chk("b2b2_level", {16'd0, A_out}, 32'h8000);
        chk("b2b2_loada", {31'd0, loadA}, 32'd1);

        // Reset mid-attack on a tick cycle.
        Reset = 1'b1;
        step_edge();
        Reset = 1'b0;
        Tick  = 1'b0;
        chk("rst_atk_level", {16'd0, A_out}, 32'd0);
        chk("rst_atk_loada", {31'd0, loadA}, 32'd0);
        chk("rst_atk_active", {31'd0, Active}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
